// File: rtl/seg_frame_ctrl_pkg.sv
// Shared opcodes, FSM encodings and command layout for the SPI-to-7-segment sequencer.
package seg_frame_ctrl_pkg;

    localparam logic [3:0] OP_WR_DIG  = 4'h1;
    localparam logic [3:0] OP_WR_ALL  = 4'h2;
    localparam logic [3:0] OP_CLEAR   = 4'h3;
    localparam logic [3:0] OP_BRIGHT  = 4'h4;

    localparam logic [3:0] BRIGHT_RST = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIG_DATA = 2'd1,
        S_ALL_DATA = 2'd2,
        S_BRT_DATA = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] arg;
    } cmd_t;

endpackage

// File: rtl/seg_frame_ctrl_if.sv
// Byte-strobe input and display-state outputs of the frame sequencer.
interface seg_frame_ctrl_if #(
    parameter int P_DIGITS = 4
);
    logic [7:0]            i_byte;
    logic                  i_byte_valid;
    logic [8*P_DIGITS-1:0] o_digits;
    logic [3:0]            o_bright;
    logic                  o_busy;
    logic                  o_frame_done;
    logic                  o_err;

    modport master (
        output i_byte, i_byte_valid,
        input  o_digits, o_bright, o_busy, o_frame_done, o_err
    );

    modport slave (
        input  i_byte, i_byte_valid,
        output o_digits, o_bright, o_busy, o_frame_done, o_err
    );
endinterface

// File: rtl/seg_frame_ctrl_frame_timer.sv
// Inter-byte watchdog: counts while a frame is open, clears on each byte, saturates at
// P_TIMEOUT-1 and flags expiry there.
module frame_timer #(
    parameter int P_TIMEOUT = 27_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);
    localparam int            TW   = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(P_TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || !i_run) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The owner leaves the running state on expiry, so this is high for one cycle.
    assign o_expired = i_run && (cnt_q == LAST);

endmodule

// File: rtl/seg_frame_ctrl.sv
// Parses SPI byte strobes into display commands; WR_ALL frames are staged in a shadow
// buffer and committed in one cycle so the display never shows a partial frame.
module seg_frame_ctrl
    import seg_frame_ctrl_pkg::*;
#(
    parameter int P_DIGITS  = 4,
    parameter int P_TIMEOUT = 27_000_000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    seg_frame_ctrl_if.slave bus
);
    localparam int            IW       = (P_DIGITS > 1) ? $clog2(P_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(P_DIGITS - 1);

    typedef logic [P_DIGITS-1:0][7:0] dig_arr_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] sel_q, sel_d;
    dig_arr_t      shadow_q, shadow_d;
    dig_arr_t      digits_q, digits_d;
    logic [3:0]    bright_q, bright_d;
    logic          busy_q;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          expired;
    cmd_t          cmd;

    assign cmd = cmd_t'(bus.i_byte);

    frame_timer #(.P_TIMEOUT(P_TIMEOUT)) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (bus.i_byte_valid),
        .i_run     (state_q != S_IDLE),
        .o_expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        digits_d = digits_q;
        bright_d = bright_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (bus.i_byte_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    case (cmd.op)
                        OP_WR_DIG: begin
                            if (32'(cmd.arg) < P_DIGITS) begin
                                sel_d   = IW'(cmd.arg);
                                state_d = S_DIG_DATA;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_WR_ALL: begin
                            idx_d   = '0;
                            state_d = S_ALL_DATA;
                        end
                        OP_CLEAR: begin
                            digits_d = '0;
                            done_d   = 1'b1;
                        end
                        OP_BRIGHT: state_d = S_BRT_DATA;
                        default:   err_d   = 1'b1;
                    endcase
                end
                S_DIG_DATA: begin
                    digits_d[sel_q] = bus.i_byte;
                    done_d          = 1'b1;
                    state_d         = S_IDLE;
                end
                S_ALL_DATA: begin
                    if (idx_q == LAST_IDX) begin
                        // Final byte bypasses the shadow so the commit happens this cycle.
                        digits_d           = shadow_q;
                        digits_d[LAST_IDX] = bus.i_byte;
                        shadow_d           = '0;
                        idx_d              = '0;
                        done_d             = 1'b1;
                        state_d            = S_IDLE;
                    end else begin
                        shadow_d[idx_q] = bus.i_byte;
                        idx_d           = idx_q + IW'(1);
                    end
                end
                S_BRT_DATA: begin
                    bright_d = bus.i_byte[3:0];
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (expired && (state_q != S_IDLE)) begin
            // A byte arriving on the expiry cycle takes the branch above instead.
            state_d  = S_IDLE;
            idx_d    = '0;
            shadow_d = '0;
            err_d    = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            sel_q    <= '0;
            shadow_q <= '0;
            digits_q <= '0;
            bright_q <= BRIGHT_RST;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            digits_q <= digits_d;
            bright_q <= bright_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.o_digits     = digits_q;
    assign bus.o_bright     = bright_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_frame_done = done_q;
    assign bus.o_err        = err_q;

endmodule

// File: tb/tb_seg_frame_ctrl.sv
// Directed bench for seg_frame_ctrl: expected done/err pulses are queued by the stimulus
// and popped by a monitor whenever the DUT pulses.
module tb_seg_frame_ctrl;
    localparam int ND = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg_frame_ctrl_if #(.P_DIGITS(ND)) bus ();

    seg_frame_ctrl #(.P_DIGITS(ND), .P_TIMEOUT(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic        done;
        logic        err;
        logic [31:0] digits;
        logic [3:0]  bright;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_pulse(input logic d, input logic e, input logic [31:0] dig,
                                input logic [3:0] br);
        exp_t x;
        x.done   = d;
        x.err    = e;
        x.digits = dig;
        x.bright = br;
        exp_q.push_back(x);
    endtask

    // Called at a negedge; returns at the next negedge so consecutive calls are back-to-back.
    task automatic send(input logic [7:0] b);
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        bus.i_byte       = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_state(input string tag, input logic [31:0] dig, input logic [3:0] br,
                             input logic busy);
        chk({tag, "_digits"}, bus.o_digits, dig);
        chk({tag, "_bright"}, 32'(bus.o_bright), 32'(br));
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'(busy));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst !== 1'b1 && (bus.o_frame_done === 1'b1 || bus.o_err === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b, expected no pulse",
                         bus.o_frame_done, bus.o_err);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", {30'd0, bus.o_frame_done, bus.o_err}, {30'd0, e.done, e.err});
                chk("pulse_digits", bus.o_digits, e.digits);
                chk("pulse_bright", 32'(bus.o_bright), 32'(e.bright));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_byte       = 8'h00;
        bus.i_byte_valid = 1'b0;
        rst              = 1'b1;
        idle(3);
        chk_state("reset", 32'h0, 4'hF, 1'b0);
        chk("reset_done", 32'(bus.o_frame_done), 32'd0);
        chk("reset_err", 32'(bus.o_err), 32'd0);
        rst = 1'b0;
        idle(1);

        // WR_DIG to digit 2
        expect_pulse(1'b1, 1'b0, 32'h003F_0000, 4'hF);
        send(8'h12);
        chk("wrdig_busy_mid", 32'(bus.o_busy), 32'd1);
        send(8'h3F);
        chk_state("wrdig", 32'h003F_0000, 4'hF, 1'b0);

        // WR_ALL: display must hold the old value until the last byte
        expect_pulse(1'b1, 1'b0, 32'h664F_5B06, 4'hF);
        send(8'h20);
        chk("wrall_busy_cmd", 32'(bus.o_busy), 32'd1);
        send(8'h06);
        send(8'h5B);
        chk_state("wrall_b2", 32'h003F_0000, 4'hF, 1'b1);
        send(8'h4F);
        chk_state("wrall_b3", 32'h003F_0000, 4'hF, 1'b1);
        send(8'h66);
        chk_state("wrall_done", 32'h664F_5B06, 4'hF, 1'b0);

        // Stalled WR_ALL times out and leaves the display alone
        expect_pulse(1'b0, 1'b1, 32'h664F_5B06, 4'hF);
        send(8'h20);
        send(8'h06);
        send(8'h5B);
        idle(14);
        chk("timeout_busy_before", 32'(bus.o_busy), 32'd1);
        idle(3);
        chk_state("timeout_after", 32'h664F_5B06, 4'hF, 1'b0);

        expect_pulse(1'b1, 1'b0, 32'h0, 4'hF);
        send(8'h30);
        chk_state("clear", 32'h0, 4'hF, 1'b0);

        // Out-of-range index and unknown opcode
        expect_pulse(1'b0, 1'b1, 32'h0, 4'hF);
        expect_pulse(1'b0, 1'b1, 32'h0, 4'hF);
        send(8'h17);
        chk("badidx_busy", 32'(bus.o_busy), 32'd0);
        send(8'h9A);
        chk_state("badop", 32'h0, 4'hF, 1'b0);

        // BRIGHT, then a BRIGHT data byte landing exactly on the expiry cycle
        expect_pulse(1'b1, 1'b0, 32'h0, 4'h3);
        send(8'h40);
        send(8'hA3);
        chk_state("bright", 32'h0, 4'h3, 1'b0);
        expect_pulse(1'b1, 1'b0, 32'h0, 4'h7);
        send(8'h40);
        idle(TO - 1);
        chk("expiry_busy", 32'(bus.o_busy), 32'd1);
        send(8'h07);
        chk_state("expiry_bright", 32'h0, 4'h7, 1'b0);

        expect_pulse(1'b1, 1'b0, 32'h0000_00AA, 4'h7);
        send(8'h10);
        send(8'hAA);
        chk_state("wrdig0", 32'h0000_00AA, 4'h7, 1'b0);

        // Reset in the middle of a WR_ALL frame
        send(8'h20);
        send(8'h11);
        rst = 1'b1;
        idle(1);
        chk_state("midrst_in", 32'h0, 4'hF, 1'b0);
        rst = 1'b0;
        idle(1);
        chk_state("midrst_out", 32'h0, 4'hF, 1'b0);

        expect_pulse(1'b1, 1'b0, 32'h5C00_0000, 4'hF);
        send(8'h13);
        send(8'h5C);
        chk_state("post_rst_wrdig", 32'h5C00_0000, 4'hF, 1'b0);

        idle(5);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
